// File: rtl/instr_fetch_seq.sv
// Multi-cycle instruction fetch sequencer: fetches from imem, holds the word until
// retirement, then captures pc_next and pulses update_pc to advance the program counter.
module instr_fetch_seq #(
    parameter int unsigned               DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0]     RESET_ADDR     = '0,
    parameter int unsigned               TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] pc_next,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_done,
    output logic                  update_pc,
    output logic [DATA_WIDTH-1:0] retire_count,
    output logic                  fault,
    output logic [1:0]            fault_cause
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_BOOT,
        S_REQ,
        S_HOLD,
        S_UPDATE,
        S_FAULT
    } state_t;

    state_t        state;
    logic [CW-1:0] timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_BOOT;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_ADDR;
            instr        <= '0;
            instr_pc     <= '0;
            instr_valid  <= 1'b0;
            update_pc    <= 1'b0;
            retire_count <= '0;
            fault        <= 1'b0;
            fault_cause  <= 2'b00;
            timer        <= '0;
        end else begin
            case (state)
                S_BOOT: begin
                    // Request is only raised for an aligned address; misalignment faults from S_REQ.
                    imem_req <= (imem_addr[1:0] == 2'b00);
                    state    <= S_REQ;
                end
                S_REQ: begin
                    if (imem_addr[1:0] != 2'b00) begin
                        imem_req    <= 1'b0;
                        fault       <= 1'b1;
                        fault_cause <= 2'b01;
                        state       <= S_FAULT;
                    end else if (imem_ready) begin
                        instr       <= imem_rdata;
                        instr_pc    <= imem_addr;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        timer       <= '0;
                        state       <= S_HOLD;
                    end else if (timer == CW'(TIMEOUT_CYCLES - 1)) begin
                        timer       <= timer + CW'(1);
                        imem_req    <= 1'b0;
                        fault       <= 1'b1;
                        fault_cause <= 2'b10;
                        state       <= S_FAULT;
                    end else begin
                        timer <= timer + CW'(1);
                    end
                end
                S_HOLD: begin
                    if (instr_done) begin
                        imem_addr    <= pc_next;
                        update_pc    <= 1'b1;
                        instr_valid  <= 1'b0;
                        retire_count <= retire_count + DATA_WIDTH'(1);
                        state        <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    update_pc <= 1'b0;
                    imem_req  <= (imem_addr[1:0] == 2'b00);
                    state     <= S_REQ;
                end
                S_FAULT: begin
                    imem_req    <= 1'b0;
                    update_pc   <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= S_FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Transaction-level bench for instr_fetch_seq: each fetch is described by address,
// latency, data, hold length and next PC; expectations follow from those numbers.
module tb_instr_fetch_seq;

    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_done;
    logic        update_pc;
    logic [31:0] retire_count;
    logic        fault;
    logic [1:0]  fault_cause;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] exp_retire;

    instr_fetch_seq #(
        .DATA_WIDTH     (32),
        .RESET_ADDR     (32'h0),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_next      (pc_next),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_done   (instr_done),
        .update_pc    (update_pc),
        .retire_count (retire_count),
        .fault        (fault),
        .fault_cause  (fault_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Asserts reset mid-cycle, checks the asynchronous effect, then releases so the
    // following edge moves the sequencer from boot into its first request cycle.
    task automatic do_reset;
        #2 rst_n = 1'b0;
        #1;
        check("rst_req", imem_req, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_retire", retire_count, 0);
        check("rst_update", update_pc, 0);
        check("rst_fault", fault, 0);
        check("rst_cause", fault_cause, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_addr", imem_addr, 0);
        exp_retire = '0;
        imem_ready = 1'b0;
        instr_done = 1'b0;
        pc_next    = '0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    // Entry: just after the edge that placed the sequencer in its request cycle for addr.
    // status: 0 = retired and now requesting nxt, 1 = faulted.
    task automatic do_fetch(input logic [31:0] addr, input int unsigned lat, input logic [31:0] data,
                            input int unsigned hold, input logic [31:0] nxt, output int status);
        int unsigned n;
        if (addr[1:0] != 2'b00) begin
            check("misalign_noreq", imem_req, 0);
            imem_ready = 1'b1;
            tick;
            imem_ready = 1'b0;
            check("misalign_fault", fault, 1);
            check("misalign_cause", fault_cause, 2'b01);
            check("misalign_req", imem_req, 0);
            status = 1;
            return;
        end
        n = (lat > TMO) ? TMO : lat;
        for (int unsigned c = 1; c <= n; c++) begin
            check("req", imem_req, 1);
            check("req_addr", imem_addr, addr);
            imem_ready = (c == lat);
            imem_rdata = (c == lat) ? data : $urandom;
            instr_done = 1'($urandom_range(0, 1));
            tick;
        end
        imem_ready = 1'b0;
        instr_done = 1'b0;
        if (lat > TMO) begin
            check("tmo_fault", fault, 1);
            check("tmo_cause", fault_cause, 2'b10);
            check("tmo_req", imem_req, 0);
            check("tmo_valid", instr_valid, 0);
            status = 1;
            return;
        end
        check("fetch_valid", instr_valid, 1);
        check("fetch_instr", instr, data);
        check("fetch_pc", instr_pc, addr);
        check("fetch_req_low", imem_req, 0);
        for (int unsigned h = 0; h < hold; h++) begin
            imem_ready = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            pc_next    = $urandom;
            tick;
            check("hold_valid", instr_valid, 1);
            check("hold_instr", instr, data);
            check("hold_update", update_pc, 0);
        end
        imem_ready = 1'b0;
        instr_done = 1'b1;
        pc_next    = nxt;
        tick;
        exp_retire = exp_retire + 32'd1;
        check("retire_update", update_pc, 1);
        check("retire_valid", instr_valid, 0);
        check("retire_count", retire_count, exp_retire);
        instr_done = 1'b0;
        pc_next    = $urandom;
        tick;
        check("pulse_end", update_pc, 0);
        check("next_addr", imem_addr, nxt);
        check("next_req", imem_req, 32'(nxt[1:0] == 2'b00));
        status = 0;
    endtask

    initial begin
        int          st;
        logic [31:0] addr;
        logic [31:0] nxt;

        rst_n      = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = '0;
        instr_done = 1'b0;
        pc_next    = '0;
        exp_retire = '0;
        tick;
        do_reset;

        // Boot fetch with single-cycle latency, retire to 0x4.
        do_fetch(32'h0, 1, 32'h0050_0093, 2, 32'h4, st);
        check("boot_status", 32'(st), 0);

        addr = 32'h4;
        for (int unsigned i = 0; i < 30; i++) begin
            nxt = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            do_fetch(addr, $urandom_range(1, TMO), $urandom, $urandom_range(0, 4), nxt, st);
            check("rand_status", 32'(st), 0);
            addr = nxt;
        end

        // Retire into a misaligned target, then confirm fault is terminal.
        do_fetch(addr, 2, $urandom, 1, 32'h102, st);
        do_fetch(32'h102, 1, $urandom, 0, 32'h0, st);
        check("misalign_status", 32'(st), 1);
        for (int unsigned i = 0; i < 5; i++) begin
            imem_ready = 1'($urandom_range(0, 1));
            instr_done = 1'($urandom_range(0, 1));
            pc_next    = $urandom;
            tick;
            check("fault_sticky", fault, 1);
            check("fault_cause_held", fault_cause, 2'b01);
            check("fault_req", imem_req, 0);
            check("fault_update", update_pc, 0);
        end
        do_reset;

        do_fetch(32'h0, TMO + 1, $urandom, 0, 32'h0, st);
        check("tmo_status", 32'(st), 1);
        do_reset;

        // Ready arriving on the final allowed cycle still completes.
        do_fetch(32'h0, TMO, 32'hCAFE_F00D, 1, 32'h8, st);
        check("tmo_edge_status", 32'(st), 0);

        // Wrap of the retirement counter.
        imem_ready = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick;
        imem_ready = 1'b0;
        check("wrap_valid", instr_valid, 1);
        force dut.retire_count = 32'hFFFF_FFFF;
        #1 release dut.retire_count;
        exp_retire = 32'hFFFF_FFFF;
        instr_done = 1'b1;
        pc_next    = 32'hC;
        tick;
        instr_done = 1'b0;
        exp_retire = exp_retire + 32'd1;
        check("wrap_count", retire_count, exp_retire);
        check("wrap_update", update_pc, 1);
        tick;

        do_fetch(32'hC, 3, $urandom, 0, 32'h10, st);
        // Reset while holding an instruction abandons it and refetches from the reset address.
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick;
        imem_ready = 1'b0;
        check("hold_before_rst", instr_valid, 1);
        do_reset;
        do_fetch(32'h0, 2, 32'h0050_0093, 0, 32'h20, st);
        check("refetch_status", 32'(st), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
